// File: rtl/lpm_arbiter_if.sv
// Client, table-write and Lpm-side handshake bundle for lpm_arbiter.
// slave is the arbiter's view; master is the view of the clients and the Lpm engine.
interface lpm_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          lookup0__ENA;
   logic [DW-1:0] lookup0__x;
   logic          lookup0__RDY;
   logic          lookup1__ENA;
   logic [DW-1:0] lookup1__x;
   logic          lookup1__RDY;
   logic          result0__ENA;
   logic [DW-1:0] result0__v;
   logic          result0__RDY;
   logic          result1__ENA;
   logic [DW-1:0] result1__v;
   logic          result1__RDY;
   logic          write__ENA;
   logic [AW-1:0] write__addr;
   logic [DW-1:0] write__data;
   logic          write__RDY;
   logic          lpm_enter__ENA;
   logic [DW-1:0] lpm_enter__x;
   logic          lpm_enter__RDY;
   logic          lpm_write__ENA;
   logic [AW-1:0] lpm_write__addr;
   logic [DW-1:0] lpm_write__data;
   logic          lpm_write__RDY;
   logic          lpm_out__ENA;
   logic [DW-1:0] lpm_out__v;
   logic          lpm_out__RDY;

   modport slave (
      input  lookup0__ENA, lookup0__x, lookup1__ENA, lookup1__x,
      input  result0__RDY, result1__RDY,
      input  write__ENA, write__addr, write__data,
      input  lpm_enter__RDY, lpm_write__RDY, lpm_out__ENA, lpm_out__v,
      output lookup0__RDY, lookup1__RDY, write__RDY,
      output result0__ENA, result0__v, result1__ENA, result1__v,
      output lpm_enter__ENA, lpm_enter__x,
      output lpm_write__ENA, lpm_write__addr, lpm_write__data,
      output lpm_out__RDY
   );

   modport master (
      output lookup0__ENA, lookup0__x, lookup1__ENA, lookup1__x,
      output result0__RDY, result1__RDY,
      output write__ENA, write__addr, write__data,
      output lpm_enter__RDY, lpm_write__RDY, lpm_out__ENA, lpm_out__v,
      input  lookup0__RDY, lookup1__RDY, write__RDY,
      input  result0__ENA, result0__v, result1__ENA, result1__v,
      input  lpm_enter__ENA, lpm_enter__x,
      input  lpm_write__ENA, lpm_write__addr, lpm_write__data,
      input  lpm_out__RDY
   );
endinterface

// File: rtl/lpm_arbiter.sv
// Shares one Lpm engine between two lookup clients and a table writer:
// round-robin lookup issue, in-order result routing via a tag FIFO, writes issued alone after a drain.
module lpm_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
) (
   input logic          CLK,
   input logic          RST,
   lpm_arbiter_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, WRITE} state_t;

   state_t         state;
   logic           prio;
   logic [CW-1:0]  count;
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [DEPTH-1:0] tags;
   logic           buf0_v, buf1_v, wbuf_v;
   logic [DW-1:0]  buf0_x, buf1_x, wbuf_d;
   logic [AW-1:0]  wbuf_a;

   logic grant, head, issue, out_rdy, pop, wfire;

   always_comb begin
      grant   = (buf0_v && buf1_v) ? prio : buf1_v;
      head    = tags[rd_ptr];
      issue   = !RST && (state == RUN) && !wbuf_v && (buf0_v || buf1_v)
                && (count != FULL) && bus.lpm_enter__RDY;
      out_rdy = !RST && (count != '0) && (head ? bus.result1__RDY : bus.result0__RDY);
      pop     = out_rdy && bus.lpm_out__ENA;
      wfire   = !RST && (state == WRITE) && bus.lpm_write__RDY;
   end

   assign bus.lookup0__RDY    = !RST && !buf0_v;
   assign bus.lookup1__RDY    = !RST && !buf1_v;
   assign bus.write__RDY      = !RST && !wbuf_v;
   assign bus.lpm_enter__ENA  = issue;
   assign bus.lpm_enter__x    = grant ? buf1_x : buf0_x;
   assign bus.lpm_write__ENA  = wfire;
   assign bus.lpm_write__addr = wbuf_a;
   assign bus.lpm_write__data = wbuf_d;
   assign bus.lpm_out__RDY    = out_rdy;
   assign bus.result0__ENA    = pop && !head;
   assign bus.result1__ENA    = pop && head;
   assign bus.result0__v      = bus.lpm_out__v;
   assign bus.result1__v      = bus.lpm_out__v;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= RUN;
         prio   <= 1'b0;
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         buf0_v <= 1'b0;
         buf1_v <= 1'b0;
         wbuf_v <= 1'b0;
      end else begin
         if (issue) begin
            tags[wr_ptr] <= grant;
            wr_ptr       <= wr_ptr + PW'(1);
            prio         <= !grant;
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({issue, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase

         if (bus.lookup0__ENA) begin
            buf0_v <= 1'b1;
            buf0_x <= bus.lookup0__x;
         end else if (issue && !grant) begin
            buf0_v <= 1'b0;
         end
         if (bus.lookup1__ENA) begin
            buf1_v <= 1'b1;
            buf1_x <= bus.lookup1__x;
         end else if (issue && grant) begin
            buf1_v <= 1'b0;
         end
         if (bus.write__ENA) begin
            wbuf_v <= 1'b1;
            wbuf_a <= bus.write__addr;
            wbuf_d <= bus.write__data;
         end else if (wfire) begin
            wbuf_v <= 1'b0;
         end

         // Drain starts on the edge the write is accepted, so an idle engine sees WRITE two cycles later.
         case (state)
            RUN:     if (wbuf_v || bus.write__ENA) state <= DRAIN;
            DRAIN:   if (count == '0 || (count == CW'(1) && pop)) state <= WRITE;
            WRITE:   if (wfire) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_lpm_arbiter.sv
// Directed bench for lpm_arbiter: queue-based model checked every cycle,
// plus literal expectations for grant order, full stall, write ordering, head blocking and reset.
module tb_lpm_arbiter;
   localparam int DEPTH = 4;

   logic CLK, RST;
   lpm_arbiter_if #(.AW(32), .DW(32)) bus();
   lpm_arbiter #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Lpm stand-in: result is the key's low byte plus 4.
   function automatic logic [31:0] res_of(logic [31:0] k);
      return {24'h0, k[7:0]} + 32'd4;
   endfunction

   // stimulus configuration, applied at each falling edge
   logic cfg_rst = 1'b1, cfg_r0 = 1'b1, cfg_r1 = 1'b1, lpm_allow = 1'b1;
   logic [31:0] q0[$], q1[$];
   logic wreq = 1'b0;
   logic [31:0] wreq_a, wreq_d;

   // model: holding slots, outstanding-issue queue, write phase (0 run, 1 drain, 2 write)
   logic        mbv[2];
   logic [31:0] mbk[2];
   logic        mwv;
   int          mph, mprio;
   int          mq[$];
   logic [31:0] lpm_pend[$];
   logic [31:0] exp0[$], exp1[$];
   int          gseq[$];
   int          iss_cyc[$];
   int ndel = 0, n_enter = 0, n_wfire = 0, wfire_ndel = 0, cyc = 0, first_pop_cyc = -1, n_r1_seen = 0;
   logic [31:0] last_r0, last_wa, last_wd;

   logic e_l0rdy, e_l1rdy, e_wrdy, e_enter, e_wen, e_ordy, e_pop, e_r0, e_r1;
   int   e_grant;
   logic [31:0] e_key;

   function automatic void model_outs();
      int hd;
      hd      = (mq.size() > 0) ? mq[0] : 0;
      e_l0rdy = !RST && !mbv[0];
      e_l1rdy = !RST && !mbv[1];
      e_wrdy  = !RST && !mwv;
      if (mbv[0] && mbv[1]) e_grant = mprio;
      else                  e_grant = mbv[1] ? 1 : 0;
      e_key   = mbk[e_grant];
      e_enter = !RST && mph == 0 && !mwv && (mbv[0] || mbv[1]) && mq.size() < DEPTH && bus.lpm_enter__RDY;
      e_wen   = !RST && mph == 2 && bus.lpm_write__RDY;
      e_ordy  = !RST && mq.size() > 0 && (hd == 1 ? bus.result1__RDY : bus.result0__RDY);
      e_pop   = e_ordy && bus.lpm_out__ENA;
      e_r0    = e_pop && hd == 0;
      e_r1    = e_pop && hd == 1;
   endfunction

   task automatic model_step();
      model_outs();
      cyc++;
      if (RST) begin
         mbv[0] = 0; mbv[1] = 0; mwv = 0; mph = 0; mprio = 0;
         mq.delete(); lpm_pend.delete(); exp0.delete(); exp1.delete();
      end else begin
         if (e_pop) begin
            void'(mq.pop_front());
            void'(lpm_pend.pop_front());
            if (e_r0 && exp0.size() > 0) void'(exp0.pop_front());
            if (e_r1 && exp1.size() > 0) void'(exp1.pop_front());
            ndel++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
         end
         if (e_enter) begin
            mq.push_back(e_grant);
            lpm_pend.push_back(res_of(e_key));
            mbv[e_grant] = 0;
            mprio = 1 - e_grant;
            gseq.push_back(e_grant);
            iss_cyc.push_back(cyc);
            n_enter++;
         end
         if (bus.lookup0__ENA) begin mbv[0] = 1; mbk[0] = bus.lookup0__x; exp0.push_back(res_of(bus.lookup0__x)); end
         if (bus.lookup1__ENA) begin mbv[1] = 1; mbk[1] = bus.lookup1__x; exp1.push_back(res_of(bus.lookup1__x)); end
         case (mph)
            0: if (mwv || bus.write__ENA) mph = 1;
            1: if (mq.size() == 0) mph = 2;
            default: if (e_wen) begin mph = 0; mwv = 0; wfire_ndel = ndel; n_wfire++; end
         endcase
         if (bus.write__ENA) mwv = 1;
      end
   endtask

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   // every-cycle comparison against the model
   initial forever begin
      @(negedge CLK);
      #2;
      model_outs();
      chk("lookup0_rdy", bus.lookup0__RDY, e_l0rdy);
      chk("lookup1_rdy", bus.lookup1__RDY, e_l1rdy);
      chk("write_rdy", bus.write__RDY, e_wrdy);
      chk("enter_ena", bus.lpm_enter__ENA, e_enter);
      chk("lpmwrite_ena", bus.lpm_write__ENA, e_wen);
      chk("out_rdy", bus.lpm_out__RDY, e_ordy);
      chk("res0_ena", bus.result0__ENA, e_r0);
      chk("res1_ena", bus.result1__ENA, e_r1);
      if (e_enter) chk("enter_key", bus.lpm_enter__x, e_key);
      if (bus.lpm_write__ENA) begin
         last_wa = bus.lpm_write__addr;
         last_wd = bus.lpm_write__data;
      end
      if (bus.result0__ENA) begin
         last_r0 = bus.result0__v;
         if (exp0.size() > 0) chk("res0_route", bus.result0__v, exp0[0]);
         else chk("res0_spurious", bus.result0__ENA, 1'b0);
      end
      if (bus.result1__ENA) begin
         n_r1_seen++;
         if (exp1.size() > 0) chk("res1_route", bus.result1__v, exp1[0]);
         else chk("res1_spurious", bus.result1__ENA, 1'b0);
      end
   end

   task automatic tick();
      int hd;
      @(negedge CLK);
      RST = cfg_rst;
      bus.result0__RDY   = cfg_r0;
      bus.result1__RDY   = cfg_r1;
      bus.lpm_enter__RDY = 1'b1;
      bus.lpm_write__RDY = 1'b1;
      bus.lookup0__ENA = 1'b0;
      bus.lookup1__ENA = 1'b0;
      bus.write__ENA   = 1'b0;
      bus.lpm_out__ENA = 1'b0;
      if (!cfg_rst) begin
         if (q0.size() > 0 && !mbv[0]) begin bus.lookup0__ENA = 1'b1; bus.lookup0__x = q0.pop_front(); end
         if (q1.size() > 0 && !mbv[1]) begin bus.lookup1__ENA = 1'b1; bus.lookup1__x = q1.pop_front(); end
         if (wreq && !mwv) begin
            bus.write__ENA = 1'b1; bus.write__addr = wreq_a; bus.write__data = wreq_d; wreq = 1'b0;
         end
         hd = (mq.size() > 0) ? mq[0] : 0;
         if (lpm_allow && lpm_pend.size() > 0 && mq.size() > 0 && (hd == 1 ? cfg_r1 : cfg_r0)) begin
            bus.lpm_out__ENA = 1'b1;
            bus.lpm_out__v   = lpm_pend[0];
         end
      end
   endtask

   task automatic wait_ge(string nm, int which, int n);
      int k = 0;
      int v;
      forever begin
         case (which)
            0: v = ndel;
            1: v = n_enter;
            2: v = n_wfire;
            default: v = mq.size();
         endcase
         if (v >= n || k >= 300) break;
         tick();
         k++;
      end
      chk(nm, (v >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int base_e, base_d, base_w, bad;
      RST = 1'b1;
      bus.lookup0__ENA = 0; bus.lookup1__ENA = 0; bus.write__ENA = 0; bus.lpm_out__ENA = 0;
      bus.lookup0__x = '0; bus.lookup1__x = '0; bus.write__addr = '0; bus.write__data = '0; bus.lpm_out__v = '0;
      bus.result0__RDY = 1; bus.result1__RDY = 1; bus.lpm_enter__RDY = 1; bus.lpm_write__RDY = 1;
      mbv[0] = 0; mbv[1] = 0; mbk[0] = '0; mbk[1] = '0; mwv = 0; mph = 0; mprio = 0;

      tick(); tick();
      #1 chk("reset_outs_zero", {bus.lookup0__RDY, bus.lookup1__RDY, bus.write__RDY, bus.lpm_enter__ENA,
             bus.lpm_write__ENA, bus.lpm_out__RDY, bus.result0__ENA, bus.result1__ENA}, '0);
      cfg_rst = 1'b0;
      tick();
      #1 chk("rdy_after_reset", {bus.lookup0__RDY, bus.lookup1__RDY, bus.write__RDY}, 3'b111);

      // contention: 8 keys per client, grants alternate from client 0
      gseq.delete();
      for (int i = 0; i < 8; i++) begin
         q0.push_back(32'h1000_0000 + i);
         q1.push_back(32'h2000_0000 + 16 + i);
      end
      wait_ge("contention_done", 0, 16);
      bad = 0;
      for (int i = 0; i < 16; i++) if (i >= gseq.size() || gseq[i] != i % 2) bad++;
      chk("grant_alternation", bad, 0);

      // single lookup from client 0
      base_d = ndel;
      n_r1_seen = 0;
      q0.push_back(32'h0A00_0001);
      wait_ge("single_done", 0, base_d + 1);
      chk("single_result", last_r0, 32'h5);
      tick(); tick();
      #1 chk("single_r1_quiet", n_r1_seen, 0);
      chk("single_count_zero", bus.lpm_out__RDY, 1'b0);

      // full: 6 lookups with results held back
      lpm_allow = 1'b0;
      base_e = n_enter;
      base_d = ndel;
      iss_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(32'h3000_0020 + i);
         q1.push_back(32'h4000_0030 + i);
      end
      repeat (20) tick();
      chk("full_enters", n_enter - base_e, 4);
      first_pop_cyc = -1;
      lpm_allow = 1'b1;
      wait_ge("full_done", 0, base_d + 6);
      chk("full_fifth_issue", (iss_cyc.size() > 4) ? iss_cyc[4] : -1, first_pop_cyc + 1);

      // write ordering behind 3 outstanding lookups
      lpm_allow = 1'b0;
      base_e = n_enter;
      base_d = ndel;
      base_w = n_wfire;
      q0.push_back(32'h5000_0041); q0.push_back(32'h5000_0042); q1.push_back(32'h6000_0051);
      wait_ge("write_pre_issue", 1, base_e + 3);
      wreq_a = 32'h10; wreq_d = 32'h7; wreq = 1'b1;
      tick();
      q0.push_back(32'h5000_0043); q1.push_back(32'h6000_0052);
      repeat (6) tick();
      chk("write_blocks_issue", n_enter - base_e, 3);
      chk("write_waits_drain", n_wfire - base_w, 0);
      lpm_allow = 1'b1;
      wait_ge("write_fired", 2, base_w + 1);
      chk("write_after_third", wfire_ndel - base_d, 3);
      chk("write_addr", last_wa, 32'h10);
      chk("write_data", last_wd, 32'h7);
      wait_ge("write_resume", 0, base_d + 5);

      // head blocking: client 1 at the head, not ready
      base_d = ndel;
      cfg_r1 = 1'b0;
      q1.push_back(32'h7000_0061);
      tick();
      q0.push_back(32'h7000_0062);
      wait_ge("head_two_out", 3, 2);
      tick(); tick();
      #1 chk("head_blocks", bus.lpm_out__RDY, 1'b0);
      cfg_r1 = 1'b1;
      tick();
      #1 chk("head_delivers", bus.result1__ENA, 1'b1);
      wait_ge("head_done", 0, base_d + 2);

      // reset with 2 lookups outstanding and a write pending
      lpm_allow = 1'b0;
      base_e = n_enter;
      q0.push_back(32'h8000_0071); q1.push_back(32'h8000_0072);
      wait_ge("rst_pre_issue", 1, base_e + 2);
      wreq_a = 32'h20; wreq_d = 32'h9; wreq = 1'b1;
      tick(); tick();
      cfg_rst = 1'b1;
      tick();
      #1 chk("midrst_outs_zero", {bus.lookup0__RDY, bus.lookup1__RDY, bus.write__RDY, bus.lpm_enter__ENA,
             bus.lpm_write__ENA, bus.lpm_out__RDY, bus.result0__ENA, bus.result1__ENA}, '0);
      tick();
      cfg_rst = 1'b0;
      lpm_allow = 1'b1;
      tick();
      #1 chk("post_rst_rdy", {bus.lookup0__RDY, bus.lookup1__RDY, bus.write__RDY, bus.lpm_out__RDY}, 4'b1110);
      gseq.delete();
      base_d = ndel;
      q0.push_back(32'h9000_0081); q1.push_back(32'h9000_0082);
      wait_ge("post_rst_done", 0, base_d + 2);
      chk("post_rst_prio0", (gseq.size() > 0) ? gseq[0] : -1, 0);

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
